// File: rtl/fp_result_sink.sv
// fp_result_sink
//   Buffers FPU results in a small show-ahead FIFO, accumulates sticky
//   exception flags and counts accepted results.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          synchronous active-high reset
//   res_valid_i    FPU result valid
//   res_ready_o    sink can accept a result (drives FPU out_ready)
//   res_data_i     FPU result
//   res_status_i   FPU exception flags {NV,DZ,OF,UF,NX} of this result
//   res_tag_i      FPU tag
//   flush_i        discard all buffered results
//   rd_en_i        consumer pops the head entry
//   rd_valid_o     head entry valid (FIFO non-empty)
//   rd_data_o      head result (show-ahead)
//   rd_status_o    head flags
//   rd_tag_o       head tag
//   count_o        occupied entries
//   fflags_o       sticky OR of flags of all accepted results
//   fflags_clr_i   clear fflags_o
//   result_cnt_o   total accepted results, saturating
module fp_result_sink #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned STATUS_W = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     res_valid_i,
  output logic                     res_ready_o,
  input  logic [DATA_W-1:0]        res_data_i,
  input  logic [STATUS_W-1:0]      res_status_i,
  input  logic                     res_tag_i,
  input  logic                     flush_i,
  input  logic                     rd_en_i,
  output logic                     rd_valid_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [STATUS_W-1:0]      rd_status_o,
  output logic                     rd_tag_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [STATUS_W-1:0]      fflags_o,
  input  logic                     fflags_clr_i,
  output logic [15:0]              result_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DATA_W + STATUS_W + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [STATUS_W-1:0]   fflags_q;
  logic [15:0]           result_cnt_q;
  logic [EW-1:0]         mem [DEPTH];
  logic                  ready;
  logic                  push, pop;

  // Ready is also dropped while flush_i is asserted so that a handshake
  // seen by the FPU in the flush cycle is never silently discarded.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    unique case (state_q)
      RUN: begin
        ready = (count_q != FULL) && !flush_i;
        if (flush_i) state_d = FLUSH;
      end
      FLUSH: begin
        ready   = 1'b0;
        state_d = flush_i ? FLUSH : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign push = res_valid_i && ready;
  assign pop  = rd_en_i && (count_q != '0) && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fflags_q     <= '0;
      result_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        if (push && !pop)      count_q <= count_q + CW'(1);
        else if (pop && !push) count_q <= count_q - CW'(1);
      end
      if (fflags_clr_i)  fflags_q <= push ? res_status_i : '0;
      else if (push)     fflags_q <= fflags_q | res_status_i;
      if (push && (result_cnt_q != '1)) result_cnt_q <= result_cnt_q + 16'd1;
    end
  end

  // Storage is not reset; head contents are meaningless while empty.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= {res_data_i, res_status_i, res_tag_i};
  end

  assign {rd_data_o, rd_status_o, rd_tag_o} = mem[rd_ptr_q];
  assign rd_valid_o   = (count_q != '0);
  assign res_ready_o  = ready;
  assign count_o      = count_q;
  assign fflags_o     = fflags_q;
  assign result_cnt_o = result_cnt_q;

endmodule

// File: doc/fp_result_sink.md
FP_RESULT_SINK -- requirements
Module: fp_result_sink

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning result FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter DATA_W, default 32, meaning result width.
REQ-003 SHALL have parameter STATUS_W, default 5, meaning FP exception flags {NV,DZ,OF,UF,NX}.
REQ-004 SHALL have port clk_i  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port res_valid_i  in  1  FPU result valid.
REQ-007 SHALL have port res_ready_o  out  1  sink can accept result (drives FPU out_ready).
REQ-008 SHALL have port res_data_i  in  DATA_W  FPU result.
REQ-009 SHALL have port res_status_i  in  STATUS_W  FPU exception flags of this result.
REQ-010 SHALL have port res_tag_i  in  1  FPU tag.
REQ-011 SHALL have port flush_i  in  1  discard all buffered results.
REQ-012 SHALL have port rd_en_i  in  1  consumer pops head entry.
REQ-013 SHALL have port rd_valid_o  out  1  head entry valid (FIFO non-empty).
REQ-014 SHALL have port rd_data_o  out  DATA_W  head result (show-ahead).
REQ-015 SHALL have port rd_status_o  out  STATUS_W  head flags.
REQ-016 SHALL have port rd_tag_o  out  1  head tag.
REQ-017 SHALL have port count_o  out  clog2(DEPTH)+1  occupied entries.
REQ-018 SHALL have port fflags_o  out  STATUS_W  sticky OR of flags of all accepted results.
REQ-019 SHALL have port fflags_clr_i  in  1  clear fflags_o.
REQ-020 SHALL have port result_cnt_o  out  16  total accepted results, saturating.

Function
REQ-021 SHALL implement FSM states RUN and FLUSH; reset state RUN.
REQ-022 SHALL in RUN drive res_ready_o = (count_o != DEPTH); in FLUSH drive res_ready_o = 0.
REQ-023 SHALL accept a result (push) exactly when res_valid_i && res_ready_o on a rising edge; no combinational path res_valid_i -> res_ready_o.
REQ-024 SHALL store {res_data_i, res_status_i, res_tag_i} at write pointer on push; pointers wrap modulo DEPTH.
REQ-025 SHALL drive rd_valid_o = (count_o != 0) and rd_data_o/rd_status_o/rd_tag_o from head entry with zero-cycle read latency.
REQ-026 SHALL pop on rd_en_i && rd_valid_o; rd_en_i when empty ignored, no pointer/count change.
REQ-027 SHALL on simultaneous push and pop keep count_o unchanged and advance both pointers; push-to-rd_valid_o latency 1 cycle; no bypass when empty.
REQ-028 SHALL on flush_i (any state) next cycle: pointers 0, count_o 0, state FLUSH; push and pop in the flush cycle suppressed.
REQ-029 SHALL return FLUSH -> RUN after exactly one cycle unless flush_i still high (remain FLUSH).
REQ-030 SHALL not change fflags_o or result_cnt_o on flush.
REQ-031 SHALL set fflags_o <= fflags_o | res_status_i on push; on fflags_clr_i without push fflags_o <= 0; with push same cycle fflags_o <= res_status_i.
REQ-032 SHALL increment result_cnt_o by 1 per push, saturating at 16'hFFFF.

Reset
REQ-033 SHALL on rst_i next edge set state RUN, pointers 0, count_o 0, rd_valid_o 0, fflags_o 0, result_cnt_o 0, res_ready_o 1; FIFO storage not reset, rd_data_o don't-care while rd_valid_o 0.
REQ-034 SHALL give rst_i priority over flush_i, push, pop, and fflags_clr_i; reset mid-stream discards all entries.

Verification
REQ-035 SHALL verify: push 0x3F800000/status 5'b00001/tag 1 -> next cycle rd_valid_o 1, rd_data_o 0x3F800000, rd_tag_o 1, count_o 1, fflags_o 5'b00001, result_cnt_o 1.
REQ-036 SHALL verify: 4 pushes with rd_en_i 0 -> count_o 4, res_ready_o 0; 5th valid held not accepted; one pop -> res_ready_o 1 next cycle, held 5th accepted, order preserved.
REQ-037 SHALL verify: count_o 2, push and pop same cycle -> count_o 2, head advances; empty with push+pop -> count_o 1, pop ignored.
REQ-038 SHALL verify: count_o 3, flush_i 1 cycle with res_valid_i 1 -> count_o 0, res_ready_o 0 for two cycles (flush cycle, FLUSH), 1 after; fflags_o and result_cnt_o unchanged.
REQ-039 SHALL verify: fflags_o 5'b10000, push status 5'b00100 with fflags_clr_i -> fflags_o 5'b00100; clr alone -> 5'b00000.
REQ-040 SHALL verify: result_cnt_o 16'hFFFF plus push -> stays 16'hFFFF; rst_i with count_o 2 -> all outputs reset values next cycle.
